// File: rtl/lsu_mem_pkg.sv
// Shared types for the LSU memory demux: address-type tag bits and lane/response payloads.
// Struct widths follow the default lane geometry (4 lanes, 4-byte words, 8-bit tags, 30-bit addr).
package lsu_mem_pkg;

  localparam int LSU_NUM_REQS   = 4;
  localparam int LSU_WORD_SIZE  = 4;
  localparam int LSU_TAG_WIDTH  = 8;
  localparam int LSU_ADDR_WIDTH = 30;

  localparam int ADDR_TYPE_SM_BIT = 0;
  localparam int ADDR_TYPE_NC_BIT = 1;

  typedef struct packed {
    logic [LSU_ADDR_WIDTH-1:0]  addr;
    logic                       rw;
    logic [LSU_WORD_SIZE-1:0]   byteen;
    logic [8*LSU_WORD_SIZE-1:0] data;
    logic [LSU_TAG_WIDTH-1:0]   tag;
  } lane_req_t;

  typedef struct packed {
    logic [LSU_NUM_REQS-1:0]                 tmask;
    logic [LSU_NUM_REQS*8*LSU_WORD_SIZE-1:0] data;
    logic [LSU_TAG_WIDTH-1:0]                tag;
  } mem_rsp_t;

endpackage

// File: rtl/lsu_mem_slot.sv
// One-entry valid/ready register, latency 1; refills on the same cycle it drains (full throughput).
// Backpressure: in_rdy_o = empty or downstream ready; held data stays stable until accepted.
module lsu_mem_slot #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_vld_i,
  output logic             in_rdy_o,
  input  logic [WIDTH-1:0] in_dat_i,
  output logic             out_vld_o,
  input  logic             out_rdy_i,
  output logic [WIDTH-1:0] out_dat_o
);

  logic             vld_q, vld_d;
  logic [WIDTH-1:0] dat_q;
  logic             push;

  assign in_rdy_o  = ~vld_q | out_rdy_i;
  assign push      = in_vld_i & in_rdy_o;
  assign out_vld_o = vld_q;
  assign out_dat_o = dat_q;

  always_comb begin
    vld_d = push | (vld_q & ~out_rdy_i);
  end

  always_ff @(posedge clk) begin
    if (reset) vld_q <= 1'b0;
    else       vld_q <= vld_d;
  end

  always_ff @(posedge clk) begin
    if (push) dat_q <= in_dat_i;
  end

endmodule

// File: rtl/lsu_mem_demux.sv
// Steers LSU lane requests to D-cache or SMEM by tag bit 0 and merges both response streams RR; latency 1 per path.
// Backpressure: per-lane and response slots stall on consumer ready. LSU_MEM_DEMUX_PERF_EN adds perf counters.
module lsu_mem_demux
  import lsu_mem_pkg::*;
#(
  parameter int NUM_REQS   = LSU_NUM_REQS,
  parameter int WORD_SIZE  = LSU_WORD_SIZE,
  parameter int TAG_WIDTH  = LSU_TAG_WIDTH,
  parameter int ADDR_WIDTH = LSU_ADDR_WIDTH
) (
  input  logic                              clk,
  input  logic                              reset,

  input  logic [NUM_REQS-1:0]               req_valid,
  input  logic [NUM_REQS-1:0]               req_rw,
  input  logic [NUM_REQS*ADDR_WIDTH-1:0]    req_addr,
  input  logic [NUM_REQS*WORD_SIZE-1:0]     req_byteen,
  input  logic [NUM_REQS*8*WORD_SIZE-1:0]   req_data,
  input  logic [NUM_REQS*TAG_WIDTH-1:0]     req_tag,
  output logic [NUM_REQS-1:0]               req_ready,

  output logic [NUM_REQS-1:0]               dc_req_valid,
  output logic [NUM_REQS-1:0]               dc_req_rw,
  output logic [NUM_REQS*ADDR_WIDTH-1:0]    dc_req_addr,
  output logic [NUM_REQS*WORD_SIZE-1:0]     dc_req_byteen,
  output logic [NUM_REQS*8*WORD_SIZE-1:0]   dc_req_data,
  output logic [NUM_REQS*TAG_WIDTH-1:0]     dc_req_tag,
  input  logic [NUM_REQS-1:0]               dc_req_ready,

  output logic [NUM_REQS-1:0]               sm_req_valid,
  output logic [NUM_REQS-1:0]               sm_req_rw,
  output logic [NUM_REQS*ADDR_WIDTH-1:0]    sm_req_addr,
  output logic [NUM_REQS*WORD_SIZE-1:0]     sm_req_byteen,
  output logic [NUM_REQS*8*WORD_SIZE-1:0]   sm_req_data,
  output logic [NUM_REQS*TAG_WIDTH-1:0]     sm_req_tag,
  input  logic [NUM_REQS-1:0]               sm_req_ready,

  input  logic                              dc_rsp_valid,
  input  logic [NUM_REQS-1:0]               dc_rsp_tmask,
  input  logic [NUM_REQS*8*WORD_SIZE-1:0]   dc_rsp_data,
  input  logic [TAG_WIDTH-1:0]              dc_rsp_tag,
  output logic                              dc_rsp_ready,

  input  logic                              sm_rsp_valid,
  input  logic [NUM_REQS-1:0]               sm_rsp_tmask,
  input  logic [NUM_REQS*8*WORD_SIZE-1:0]   sm_rsp_data,
  input  logic [TAG_WIDTH-1:0]              sm_rsp_tag,
  output logic                              sm_rsp_ready,

  output logic                              rsp_valid,
  output logic [NUM_REQS-1:0]               rsp_tmask,
  output logic [NUM_REQS*8*WORD_SIZE-1:0]   rsp_data,
  output logic [TAG_WIDTH-1:0]              rsp_tag,
  input  logic                              rsp_ready,

  output logic                              idle
`ifdef LSU_MEM_DEMUX_PERF_EN
  ,
  output logic [63:0]                       perf_dc_reqs,
  output logic [63:0]                       perf_sm_reqs,
  output logic [63:0]                       perf_rsp_stalls
`endif
);

  localparam int DW = 8 * WORD_SIZE;

  logic [NUM_REQS-1:0] slot_vld;

  for (genvar i = 0; i < NUM_REQS; i++) begin : g_lane
    lane_req_t lane_in, lane_q;
    logic      lane_vld, tgt_sm, tgt_rdy;

    assign lane_in.addr   = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign lane_in.rw     = req_rw[i];
    assign lane_in.byteen = req_byteen[i*WORD_SIZE +: WORD_SIZE];
    assign lane_in.data   = req_data[i*DW +: DW];
    assign lane_in.tag    = req_tag[i*TAG_WIDTH +: TAG_WIDTH];

    lsu_mem_slot #(.WIDTH($bits(lane_req_t))) u_slot (
      .clk       (clk),
      .reset     (reset),
      .in_vld_i  (req_valid[i]),
      .in_rdy_o  (req_ready[i]),
      .in_dat_i  (lane_in),
      .out_vld_o (lane_vld),
      .out_rdy_i (tgt_rdy),
      .out_dat_o (lane_q)
    );

    // NC requests (tag bit 1) deliberately stay on the D-cache side.
    assign tgt_sm   = lane_q.tag[ADDR_TYPE_SM_BIT];
    assign tgt_rdy  = tgt_sm ? sm_req_ready[i] : dc_req_ready[i];
    assign slot_vld[i] = lane_vld;

    assign dc_req_valid[i]                          = lane_vld & ~tgt_sm;
    assign dc_req_rw[i]                             = lane_q.rw;
    assign dc_req_addr[i*ADDR_WIDTH +: ADDR_WIDTH]  = lane_q.addr;
    assign dc_req_byteen[i*WORD_SIZE +: WORD_SIZE]  = lane_q.byteen;
    assign dc_req_data[i*DW +: DW]                  = lane_q.data;
    assign dc_req_tag[i*TAG_WIDTH +: TAG_WIDTH]     = lane_q.tag;

    assign sm_req_valid[i]                          = lane_vld & tgt_sm;
    assign sm_req_rw[i]                             = lane_q.rw;
    assign sm_req_addr[i*ADDR_WIDTH +: ADDR_WIDTH]  = lane_q.addr;
    assign sm_req_byteen[i*WORD_SIZE +: WORD_SIZE]  = lane_q.byteen;
    assign sm_req_data[i*DW +: DW]                  = lane_q.data;
    assign sm_req_tag[i*TAG_WIDTH +: TAG_WIDTH]     = lane_q.tag;
  end

  mem_rsp_t dc_rsp, sm_rsp, rsp_in, rsp_q;
  logic     rsp_in_vld, rsp_in_rdy, rsp_vld_q, grant_sm;
  logic     prio_sm_q, prio_sm_d;

  assign dc_rsp.tmask = dc_rsp_tmask;
  assign dc_rsp.data  = dc_rsp_data;
  assign dc_rsp.tag   = dc_rsp_tag;
  assign sm_rsp.tmask = sm_rsp_tmask;
  assign sm_rsp.data  = sm_rsp_data;
  assign sm_rsp.tag   = sm_rsp_tag;

  assign grant_sm     = sm_rsp_valid & (~dc_rsp_valid | prio_sm_q);
  assign rsp_in_vld   = dc_rsp_valid | sm_rsp_valid;
  assign rsp_in       = grant_sm ? sm_rsp : dc_rsp;
  assign dc_rsp_ready = rsp_in_rdy & ~grant_sm;
  assign sm_rsp_ready = rsp_in_rdy & grant_sm;

  // Priority moves to whichever source lost (or did not compete) on every grant.
  always_comb begin
    prio_sm_d = prio_sm_q;
    if (rsp_in_vld & rsp_in_rdy) prio_sm_d = ~grant_sm;
  end

  always_ff @(posedge clk) begin
    if (reset) prio_sm_q <= 1'b0;
    else       prio_sm_q <= prio_sm_d;
  end

  lsu_mem_slot #(.WIDTH($bits(mem_rsp_t))) u_rsp_slot (
    .clk       (clk),
    .reset     (reset),
    .in_vld_i  (rsp_in_vld),
    .in_rdy_o  (rsp_in_rdy),
    .in_dat_i  (rsp_in),
    .out_vld_o (rsp_vld_q),
    .out_rdy_i (rsp_ready),
    .out_dat_o (rsp_q)
  );

  assign rsp_valid = rsp_vld_q;
  assign rsp_tmask = rsp_q.tmask;
  assign rsp_data  = rsp_q.data;
  assign rsp_tag   = rsp_q.tag;

  assign idle = ~|slot_vld & ~rsp_vld_q;

`ifdef LSU_MEM_DEMUX_PERF_EN
  localparam int CW = $clog2(NUM_REQS + 1);

  logic [NUM_REQS-1:0] dc_fire, sm_fire;
  logic [CW-1:0]       dc_pop, sm_pop;
  logic [64:0]         dc_sum, sm_sum, st_sum;
  logic [63:0]         perf_dc_q, perf_dc_d, perf_sm_q, perf_sm_d, perf_st_q, perf_st_d;

  assign dc_fire = dc_req_valid & dc_req_ready;
  assign sm_fire = sm_req_valid & sm_req_ready;

  always_comb begin
    dc_pop = '0;
    sm_pop = '0;
    for (int k = 0; k < NUM_REQS; k++) begin
      dc_pop = dc_pop + {{(CW-1){1'b0}}, dc_fire[k]};
      sm_pop = sm_pop + {{(CW-1){1'b0}}, sm_fire[k]};
    end
    // A carry out of bit 63 pins the counter at all-ones.
    dc_sum    = {1'b0, perf_dc_q} + {{(65-CW){1'b0}}, dc_pop};
    sm_sum    = {1'b0, perf_sm_q} + {{(65-CW){1'b0}}, sm_pop};
    st_sum    = {1'b0, perf_st_q} + {64'd0, rsp_vld_q & ~rsp_ready};
    perf_dc_d = dc_sum[64] ? '1 : dc_sum[63:0];
    perf_sm_d = sm_sum[64] ? '1 : sm_sum[63:0];
    perf_st_d = st_sum[64] ? '1 : st_sum[63:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_dc_q <= '0;
      perf_sm_q <= '0;
      perf_st_q <= '0;
    end else begin
      perf_dc_q <= perf_dc_d;
      perf_sm_q <= perf_sm_d;
      perf_st_q <= perf_st_d;
    end
  end

  assign perf_dc_reqs    = perf_dc_q;
  assign perf_sm_reqs    = perf_sm_q;
  assign perf_rsp_stalls = perf_st_q;
`endif

endmodule

// File: tb/tb_lsu_mem_demux.sv
// Scoreboard bench for lsu_mem_demux: a cycle model of lane and response slots predicts every output.
// Directed phases cover routing, stalls, RR alternation, throughput, idle and reset; a random phase follows.
module tb_lsu_mem_demux;
  localparam int N  = 4;
  localparam int AW = 30;
  localparam int WS = 4;
  localparam int DW = 32;
  localparam int TW = 8;

  logic clk = 1'b0;
  logic reset;
  logic [N-1:0]    req_valid, req_rw, req_ready;
  logic [N*AW-1:0] req_addr;
  logic [N*WS-1:0] req_byteen;
  logic [N*DW-1:0] req_data;
  logic [N*TW-1:0] req_tag;
  logic [N-1:0]    dc_req_valid, dc_req_rw, dc_req_ready, sm_req_valid, sm_req_rw, sm_req_ready;
  logic [N*AW-1:0] dc_req_addr, sm_req_addr;
  logic [N*WS-1:0] dc_req_byteen, sm_req_byteen;
  logic [N*DW-1:0] dc_req_data, sm_req_data;
  logic [N*TW-1:0] dc_req_tag, sm_req_tag;
  logic            dc_rsp_valid, dc_rsp_ready, sm_rsp_valid, sm_rsp_ready;
  logic [N-1:0]    dc_rsp_tmask, sm_rsp_tmask, rsp_tmask;
  logic [N*DW-1:0] dc_rsp_data, sm_rsp_data, rsp_data;
  logic [TW-1:0]   dc_rsp_tag, sm_rsp_tag, rsp_tag;
  logic            rsp_valid, rsp_ready, idle;
`ifdef LSU_MEM_DEMUX_PERF_EN
  logic [63:0]     perf_dc_reqs, perf_sm_reqs, perf_rsp_stalls;
  logic [63:0]     m_dc, m_sm, m_st;
`endif

  lsu_mem_demux dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_rw(req_rw), .req_addr(req_addr), .req_byteen(req_byteen),
    .req_data(req_data), .req_tag(req_tag), .req_ready(req_ready),
    .dc_req_valid(dc_req_valid), .dc_req_rw(dc_req_rw), .dc_req_addr(dc_req_addr),
    .dc_req_byteen(dc_req_byteen), .dc_req_data(dc_req_data), .dc_req_tag(dc_req_tag),
    .dc_req_ready(dc_req_ready),
    .sm_req_valid(sm_req_valid), .sm_req_rw(sm_req_rw), .sm_req_addr(sm_req_addr),
    .sm_req_byteen(sm_req_byteen), .sm_req_data(sm_req_data), .sm_req_tag(sm_req_tag),
    .sm_req_ready(sm_req_ready),
    .dc_rsp_valid(dc_rsp_valid), .dc_rsp_tmask(dc_rsp_tmask), .dc_rsp_data(dc_rsp_data),
    .dc_rsp_tag(dc_rsp_tag), .dc_rsp_ready(dc_rsp_ready),
    .sm_rsp_valid(sm_rsp_valid), .sm_rsp_tmask(sm_rsp_tmask), .sm_rsp_data(sm_rsp_data),
    .sm_rsp_tag(sm_rsp_tag), .sm_rsp_ready(sm_rsp_ready),
    .rsp_valid(rsp_valid), .rsp_tmask(rsp_tmask), .rsp_data(rsp_data), .rsp_tag(rsp_tag),
    .rsp_ready(rsp_ready), .idle(idle)
`ifdef LSU_MEM_DEMUX_PERF_EN
    , .perf_dc_reqs(perf_dc_reqs), .perf_sm_reqs(perf_sm_reqs), .perf_rsp_stalls(perf_rsp_stalls)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            sm;
    logic [AW-1:0] addr;
    logic          rw;
    logic [WS-1:0] be;
    logic [DW-1:0] data;
    logic [TW-1:0] tag;
  } exp_req_t;

  typedef struct {
    logic [N-1:0]    tmask;
    logic [N*DW-1:0] data;
    logic [TW-1:0]   tag;
  } exp_rsp_t;

  exp_req_t rq[N][$];
  exp_rsp_t rspq[$];
  bit       prio_m;
  int       checks = 0;
  int       errors = 0;

  int            req_prob = 0, dc_rdy_prob = 0, sm_rdy_prob = 0, rsp_prob = 0, rsp_rdy_prob = 0;
  logic [N-1:0]  lane_en = '0;
  bit            fixed_tag_en = 1'b0;
  logic [TW-1:0] fixed_tag [N];
  logic [N-1:0]  lane_fired = '0;
  bit            dcr_fired = 1'b0, smr_fired = 1'b0;

  task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic bit roll(input int p);
    return int'($urandom_range(99)) < p;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (!(req_valid[i] && !lane_fired[i])) begin
        if (lane_en[i] && roll(req_prob)) begin
          req_valid[i]            = 1'b1;
          req_rw[i]               = 1'($urandom);
          req_addr[i*AW +: AW]    = AW'($urandom);
          req_byteen[i*WS +: WS]  = WS'($urandom);
          req_data[i*DW +: DW]    = $urandom;
          req_tag[i*TW +: TW]     = fixed_tag_en ? fixed_tag[i] : TW'($urandom);
        end else begin
          req_valid[i] = 1'b0;
        end
      end
      dc_req_ready[i] = roll(dc_rdy_prob);
      sm_req_ready[i] = roll(sm_rdy_prob);
    end
    if (!(dc_rsp_valid && !dcr_fired)) begin
      dc_rsp_valid = roll(rsp_prob);
      dc_rsp_tmask = N'($urandom);
      dc_rsp_data  = {$urandom, $urandom, $urandom, $urandom};
      dc_rsp_tag   = TW'($urandom);
    end
    if (!(sm_rsp_valid && !smr_fired)) begin
      sm_rsp_valid = roll(rsp_prob);
      sm_rsp_tmask = N'($urandom);
      sm_rsp_data  = {$urandom, $urandom, $urandom, $urandom};
      sm_rsp_tag   = TW'($urandom);
    end
    rsp_ready = roll(rsp_rdy_prob);
  endtask

  task automatic monitor_cycle();
    exp_req_t e;
    exp_rsp_t r;
    bit ev, es, er, ef, acc, gs, idle_m;
    logic [N-1:0] dcf, smf;
    logic [74:0]  act;
    idle_m = (rspq.size() == 0);
    for (int i = 0; i < N; i++) if (rq[i].size() != 0) idle_m = 1'b0;
    check_eq("idle", 128'(idle), 128'(idle_m));
    for (int i = 0; i < N; i++) begin
      ev = rq[i].size() != 0;
      es = ev && rq[i][0].sm;
      check_eq($sformatf("dc_vld%0d", i), 128'(dc_req_valid[i]), 128'(ev && !es));
      check_eq($sformatf("sm_vld%0d", i), 128'(sm_req_valid[i]), 128'(ev && es));
      if (ev) begin
        e = rq[i][0];
        act = es ? {sm_req_addr[i*AW +: AW], sm_req_rw[i], sm_req_byteen[i*WS +: WS],
                    sm_req_data[i*DW +: DW], sm_req_tag[i*TW +: TW]}
                 : {dc_req_addr[i*AW +: AW], dc_req_rw[i], dc_req_byteen[i*WS +: WS],
                    dc_req_data[i*DW +: DW], dc_req_tag[i*TW +: TW]};
        check_eq($sformatf("req_pay%0d", i), 128'(act), 128'({e.addr, e.rw, e.be, e.data, e.tag}));
      end
      er = !ev || (es ? sm_req_ready[i] : dc_req_ready[i]);
      check_eq($sformatf("req_rdy%0d", i), 128'(req_ready[i]), 128'(er));
      dcf[i] = ev && !es && dc_req_ready[i];
      smf[i] = ev && es && sm_req_ready[i];
      if (dcf[i] || smf[i]) void'(rq[i].pop_front());
      lane_fired[i] = req_valid[i] && er;
      if (lane_fired[i]) begin
        e.sm   = req_tag[i*TW];
        e.addr = req_addr[i*AW +: AW];
        e.rw   = req_rw[i];
        e.be   = req_byteen[i*WS +: WS];
        e.data = req_data[i*DW +: DW];
        e.tag  = req_tag[i*TW +: TW];
        rq[i].push_back(e);
      end
    end
    ef = rspq.size() != 0;
    check_eq("rsp_vld", 128'(rsp_valid), 128'(ef));
    if (ef) begin
      check_eq("rsp_data", rsp_data, rspq[0].data);
      check_eq("rsp_tm_tag", 128'({rsp_tmask, rsp_tag}), 128'({rspq[0].tmask, rspq[0].tag}));
    end
    acc = !ef || rsp_ready;
    gs  = sm_rsp_valid && (!dc_rsp_valid || prio_m);
    if (dc_rsp_valid) check_eq("dc_rsp_rdy", 128'(dc_rsp_ready), 128'(acc && !gs));
    if (sm_rsp_valid) check_eq("sm_rsp_rdy", 128'(sm_rsp_ready), 128'(acc && gs));
`ifdef LSU_MEM_DEMUX_PERF_EN
    check_eq("perf_dc", 128'(perf_dc_reqs), 128'(m_dc));
    check_eq("perf_sm", 128'(perf_sm_reqs), 128'(m_sm));
    check_eq("perf_st", 128'(perf_rsp_stalls), 128'(m_st));
    m_dc = m_dc + 64'($countones(dcf));
    m_sm = m_sm + 64'($countones(smf));
    m_st = m_st + 64'(ef && !rsp_ready);
`endif
    if (ef && rsp_ready) void'(rspq.pop_front());
    dcr_fired = dc_rsp_valid && acc && !gs;
    smr_fired = sm_rsp_valid && acc && gs;
    if ((dc_rsp_valid || sm_rsp_valid) && acc) begin
      r.tmask = gs ? sm_rsp_tmask : dc_rsp_tmask;
      r.data  = gs ? sm_rsp_data  : dc_rsp_data;
      r.tag   = gs ? sm_rsp_tag   : dc_rsp_tag;
      rspq.push_back(r);
      prio_m = !gs;
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      for (int i = 0; i < N; i++) rq[i].delete();
      rspq.delete();
      prio_m     = 1'b0;
      lane_fired = '0;
      dcr_fired  = 1'b0;
      smr_fired  = 1'b0;
`ifdef LSU_MEM_DEMUX_PERF_EN
      m_dc = '0; m_sm = '0; m_st = '0;
`endif
    end else begin
      monitor_cycle();
    end
  end

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_idle"}, 128'(idle), 128'(1));
    check_eq({tag, "_vlds"}, 128'({dc_req_valid, sm_req_valid, rsp_valid}), 128'(0));
`ifdef LSU_MEM_DEMUX_PERF_EN
    check_eq({tag, "_perf"}, 128'(perf_dc_reqs | perf_sm_reqs | perf_rsp_stalls), 128'(0));
`endif
  endtask

  logic [AW-1:0] sv_addr0, sv_addr1;
  logic [DW-1:0] sv_data0;
  logic [TW-1:0] sv_tag;
  logic          prev;

  initial begin
    reset = 1'b1;
    req_valid = '0; req_rw = '0; req_addr = '0; req_byteen = '0; req_data = '0; req_tag = '0;
    dc_req_ready = '0; sm_req_ready = '0;
    dc_rsp_valid = 1'b0; dc_rsp_tmask = '0; dc_rsp_data = '0; dc_rsp_tag = '0;
    sm_rsp_valid = 1'b0; sm_rsp_tmask = '0; sm_rsp_data = '0; sm_rsp_tag = '0;
    rsp_ready = 1'b0;
    for (int i = 0; i < N; i++) fixed_tag[i] = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_reset_state("rst");

    // Routing: lane 0 -> SMEM, lane 1 -> D-cache.
    dc_rdy_prob = 100; sm_rdy_prob = 100; rsp_rdy_prob = 100;
    fixed_tag_en = 1'b1; fixed_tag[0] = 8'h01; fixed_tag[1] = 8'h00;
    lane_en = 4'b0011; req_prob = 100;
    step();
    sv_addr0 = req_addr[0 +: AW]; sv_addr1 = req_addr[AW +: AW]; sv_data0 = req_data[0 +: DW];
    lane_en = '0;
    step();
    @(negedge clk);
    check_eq("t1_sm_vld", 128'(sm_req_valid), 128'(4'b0001));
    check_eq("t1_dc_vld", 128'(dc_req_valid), 128'(4'b0010));
    check_eq("t1_sm_addr", 128'(sm_req_addr[0 +: AW]), 128'(sv_addr0));
    check_eq("t1_sm_data", 128'(sm_req_data[0 +: DW]), 128'(sv_data0));
    check_eq("t1_dc_addr", 128'(dc_req_addr[AW +: AW]), 128'(sv_addr1));

    // SMEM stall on lane 0: slot holds, lane back-pressures, releases once.
    sm_rdy_prob = 0; lane_en = 4'b0001;
    step();
    step();
    @(negedge clk);
    check_eq("t2_rdy_a", 128'(req_ready[0]), 128'(0));
    sv_addr0 = sm_req_addr[0 +: AW];
    for (int k = 0; k < 2; k++) begin
      step();
      @(negedge clk);
      check_eq("t2_rdy_b", 128'(req_ready[0]), 128'(0));
      check_eq("t2_stable", 128'(sm_req_addr[0 +: AW]), 128'(sv_addr0));
    end
    sm_rdy_prob = 100; lane_en = '0;
    step();
    @(negedge clk);
    check_eq("t2_release", 128'(req_ready[0]), 128'(1));
    repeat (3) step();

    // Both response sources valid: grants must alternate.
    rsp_prob = 100; rsp_rdy_prob = 100;
    for (int k = 0; k < 4; k++) begin
      step();
      @(negedge clk);
      check_eq("t3_onehot", 128'(dc_rsp_ready ^ sm_rsp_ready), 128'(1));
      if (k > 0) check_eq("t3_alt", 128'(dc_rsp_ready), 128'(!prev));
      prev = dc_rsp_ready;
    end

    // Response slot full with LSU stalled.
    rsp_rdy_prob = 0;
    step();
    @(negedge clk);
    sv_tag = rsp_tag;
    for (int k = 0; k < 3; k++) begin
      check_eq("t4_rdys", 128'({dc_rsp_ready, sm_rsp_ready}), 128'(0));
      check_eq("t4_stable", 128'(rsp_tag), 128'(sv_tag));
      step();
      @(negedge clk);
    end
    rsp_prob = 0; rsp_rdy_prob = 100;
    repeat (3) step();

    // Full throughput on all lanes, then idle returns.
    fixed_tag_en = 1'b0; lane_en = 4'hF; req_prob = 100;
    for (int k = 0; k < 16; k++) begin
      step();
      @(negedge clk);
      check_eq("t5_rdy", 128'(req_ready), 128'(4'hF));
      if (k > 0) check_eq("t5_busy", 128'(idle), 128'(0));
    end
    lane_en = '0;
    step();
    @(negedge clk);
    check_eq("t5_last", 128'(idle), 128'(0));
    step();
    @(negedge clk);
    check_eq("t5_idle", 128'(idle), 128'(1));

    // Reset with three lane slots occupied.
    fixed_tag_en = 1'b1; fixed_tag[0] = 8'h00; fixed_tag[1] = 8'h00; fixed_tag[2] = 8'h00;
    dc_rdy_prob = 0; lane_en = 4'b0111;
    step();
    lane_en = '0;
    step();
    @(negedge clk);
    check_eq("t6_full", 128'(dc_req_valid), 128'(4'b0111));
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clk);
    check_reset_state("t6");

    // Random traffic with one mid-run reset.
    fixed_tag_en = 1'b0;
    for (int k = 0; k < 600; k++) begin
      if (k % 25 == 0) begin
        lane_en      = N'($urandom);
        req_prob     = $urandom_range(100);
        dc_rdy_prob  = $urandom_range(100);
        sm_rdy_prob  = $urandom_range(100);
        rsp_prob     = $urandom_range(100);
        rsp_rdy_prob = $urandom_range(100);
      end
      step();
      reset = (k == 300);
    end
    reset = 1'b0;
    step();
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/lsu_mem_demux.md
Name: lsu_mem_demux

Overview:
- Sits directly downstream of the LSU unit's per-thread data-cache request port and upstream of the D-cache and shared-memory (SMEM) banks.
- Steers each lane's request to D-cache or SMEM using the address-type bits carried in the tag LSBs.
- Merges the two response streams back into the single response port the LSU consumes.
- One registered stage on each path.

Parameters:
NUM_REQS, 4, lanes (= NUM_THREADS)
WORD_SIZE, 4, bytes per lane word
TAG_WIDTH, 8, request/response tag width; bit 0 = is_addr_sm, bit 1 = is_addr_nc
ADDR_WIDTH, 30, word address width

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
req_valid/req_rw/req_ready  in/in/out  NUM_REQS each  per-lane LSU request handshake, write flag
req_addr/req_byteen/req_data/req_tag  in  NUM_REQS*{ADDR_WIDTH,WORD_SIZE,8*WORD_SIZE,TAG_WIDTH}  request payload
dc_req_*/sm_req_*  out (ready in)  same shapes as req_*  D-cache / SMEM request ports
dc_rsp_valid/sm_rsp_valid  in  1  response valid
dc_rsp_tmask/sm_rsp_tmask  in  NUM_REQS  lane mask
dc_rsp_data/sm_rsp_data  in  NUM_REQS*8*WORD_SIZE  response data
dc_rsp_tag/sm_rsp_tag  in  TAG_WIDTH  response tag
dc_rsp_ready/sm_rsp_ready  out  1  response accept
rsp_valid/rsp_tmask/rsp_data/rsp_tag  out  1/NUM_REQS/NUM_REQS*8*WORD_SIZE/TAG_WIDTH  merged response to LSU
rsp_ready  in  1  LSU accept
idle  out  1  high when every buffer is empty

Behaviour:
- Clock is clk. Reset is synchronous, active-high.
- Reset: all buffer valids cleared; dc_req_valid, sm_req_valid, rsp_valid = 0; idle = 1; RR priority = dcache.
- Request path, per lane i, independent:
  - One-entry slot.
  - Target = SMEM if req_tag[i][0] else D-cache.
  - req_ready[i] = ~slot_valid[i] | target_ready[i], where target_ready is the ready of the target held in the slot.
  - Accepted request appears on the target port the next cycle (latency 1); the other target's valid stays 0.
  - On simultaneous pop and push, the slot reloads with no bubble, giving full throughput.
  - Tag, addr, data, byteen and rw pass through unmodified.
- Response path: one-entry output slot.
  - Slot accepts when empty or when rsp_ready=1.
  - Only dc valid, or only sm valid: grant it.
  - Both valid: grant the RR priority source; the other source's ready = 0.
  - After a grant, priority flips to the non-granted source.
  - Granted source's rsp_ready = slot accept condition.
  - Output latency 1 cycle. Data, tmask and tag are forwarded unchanged.
- Holding rules:
  - No request lane or response slot drops data while its consumer is not ready.
  - The held payload stays stable until accepted.
- idle = ~|slot_valid & ~rsp_slot_valid. The LSU uses it for fence completion.
- Reset mid-transfer: all in-flight slot contents are discarded and valids forced to 0 on the reset cycle.
- NC requests (tag bit 1) route to the D-cache; IO handling happens inside the cache.

Optional Feature:
- LSU_MEM_DEMUX_PERF_EN
- Defined: adds outputs perf_dc_reqs and perf_sm_reqs (each 64, out) and perf_rsp_stalls (64, out).
  - perf_dc_reqs and perf_sm_reqs increment by popcount of lanes firing to that target per cycle.
  - perf_rsp_stalls increments each cycle rsp_valid & ~rsp_ready.
  - All counters reset to 0 and saturate at all-ones.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package lsu_mem_pkg holds:
  - ADDR_TYPE_SM_BIT=0 and ADDR_TYPE_NC_BIT=1
  - the lane request struct typedef (addr, rw, byteen, data, tag)
  - the response struct typedef
- One sub-module, lsu_mem_slot: parameterised-width one-entry valid/ready register with bypass-free full throughput. Instantiated per lane and once for the response path.

Test Plan:
- Lane 0 tag=0x01, lane 1 tag=0x00, both ready high → next cycle sm_req_valid=4'b0001 and dc_req_valid=4'b0010, addr/data identical to the inputs.
- sm_req_ready=0 for 3 cycles with lane 0 held → req_ready[0]=0 from cycle 1; payload stable; fires on the cycle ready rises; no duplicate.
- dc_rsp and sm_rsp valid together for 4 cycles, rsp_ready=1 → grants alternate dc, sm, dc, sm; rsp_tag matches the granted source's tag each cycle.
- rsp_ready=0 with the slot full → both dc_rsp_ready=0 and sm_rsp_ready=0; slot data unchanged until rsp_ready=1.
- Back-to-back requests on all 4 lanes, targets always ready → 1 request per lane per cycle sustained for 16 cycles; idle=0, returning to 1 one cycle after the last pop.
- Assert reset with 3 slots full → the next cycle all valids are 0 and idle=1; with LSU_MEM_DEMUX_PERF_EN, counters read 0.
